// File: rtl/bo_datapath_pkg.sv
// Shared encodings for the polynomial datapath and its control sequencer.
// Select and opcode values are fixed by the sequencer's control word layout.
package bo_pkg;

    typedef enum logic [1:0] {
        SEL_A_H    = 2'b00,
        SEL_A_X    = 2'b01,
        SEL_A_S    = 2'b10,
        SEL_A_ZERO = 2'b11
    } sel_a_e;

    typedef enum logic [1:0] {
        SEL_B_K = 2'b00,
        SEL_B_H = 2'b01,
        SEL_B_S = 2'b10,
        SEL_B_X = 2'b11
    } sel_b_e;

    typedef enum logic [1:0] {
        K0 = 2'b00,
        K1 = 2'b01,
        K2 = 2'b10,
        K3 = 2'b11
    } sel_k_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } alu_op_e;

    localparam int unsigned DEFAULT_WIDTH = 16;

    // The last stage of every schedule is an add of k3 into S.
    function automatic logic is_final_stage(input logic ls, input sel_k_e ksel);
        return ls && (ksel == K3);
    endfunction

endpackage

// File: rtl/bo_datapath_if.sv
// Control/data bundle between the control sequencer (master) and the datapath (slave).
// Signal names match the sequencer's existing control outputs.
interface bo_datapath_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0]   x_in;
    logic [4*WIDTH-1:0] coef;
    logic               LX;
    logic               LS;
    logic               LH;
    logic               Hula;
    logic [1:0]         M0;
    logic [1:0]         M1;
    logic [1:0]         M2;
    logic [WIDTH-1:0]   y_out;
    logic               y_valid;
    logic               ovf;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   s_q;
    logic [WIDTH-1:0]   h_q;

    modport master (
        output x_in, coef, LX, LS, LH, Hula, M0, M1, M2,
        input  y_out, y_valid, ovf, x_q, s_q, h_q
    );

    modport slave (
        input  x_in, coef, LX, LS, LH, Hula, M0, M1, M2,
        output y_out, y_valid, ovf, x_q, s_q, h_q
    );

endinterface

// File: rtl/bo_datapath_alu.sv
// Combinational add/multiply ALU; result truncated to WIDTH bits with an
// unsigned overflow indication.
module bo_alu
    import bo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             ovf_evt
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        result  = '0;
        ovf_evt = 1'b0;
        case (op)
            OP_ADD: begin
                result  = sum[WIDTH-1:0];
                ovf_evt = sum[WIDTH];
            end
            OP_MUL: begin
                result  = prod[WIDTH-1:0];
                ovf_evt = |prod[2*WIDTH-1:WIDTH];
            end
            default: begin
                result  = '0;
                ovf_evt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bo_datapath.sv
// Polynomial datapath: X/S/H registers, coefficient and operand muxes, ALU,
// result capture with valid pulse and a sticky overflow flag.
module bo_datapath
    import bo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    bo_datapath_if.slave  bus
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             yv_q, yv_d;
    logic             ovf_q, ovf_d;

    sel_k_e           k_sel;
    sel_a_e           a_sel;
    sel_b_e           b_sel;
    alu_op_e          op;

    logic [WIDTH-1:0] k_val;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_res;
    logic             alu_evt;
    logic             evt_counted;
    logic             capture;

    assign k_sel = sel_k_e'(bus.M0);
    assign a_sel = sel_a_e'(bus.M1);
    assign b_sel = sel_b_e'(bus.M2);
    assign op    = alu_op_e'(bus.Hula);

    always_comb begin
        k_val = '0;
        case (k_sel)
            K0:      k_val = bus.coef[0*WIDTH +: WIDTH];
            K1:      k_val = bus.coef[1*WIDTH +: WIDTH];
            K2:      k_val = bus.coef[2*WIDTH +: WIDTH];
            K3:      k_val = bus.coef[3*WIDTH +: WIDTH];
            default: k_val = '0;
        endcase
    end

    always_comb begin
        opa = '0;
        case (a_sel)
            SEL_A_H:    opa = h_q;
            SEL_A_X:    opa = x_q;
            SEL_A_S:    opa = s_q;
            SEL_A_ZERO: opa = '0;
            default:    opa = '0;
        endcase
    end

    always_comb begin
        opb = '0;
        case (b_sel)
            SEL_B_K: opb = k_val;
            SEL_B_H: opb = h_q;
            SEL_B_S: opb = s_q;
            SEL_B_X: opb = x_q;
            default: opb = '0;
        endcase
    end

    bo_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a       (opa),
        .b       (opb),
        .op      (op),
        .result  (alu_res),
        .ovf_evt (alu_evt)
    );

    always_comb begin
        evt_counted = alu_evt && (bus.LS || bus.LH);
        capture     = is_final_stage(bus.LS, k_sel);

        x_d  = bus.LX ? bus.x_in : x_q;
        s_d  = bus.LS ? alu_res  : s_q;
        h_d  = bus.LH ? alu_res  : h_q;
        y_d  = capture ? alu_res : y_q;
        yv_d = capture;
        // A new sample clears the flag, but an event in that same cycle already
        // belongs to the new sample and must survive the clear.
        ovf_d = bus.LX ? evt_counted : (ovf_q || evt_counted);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q   <= '0;
            s_q   <= '0;
            h_q   <= '0;
            y_q   <= '0;
            yv_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            s_q   <= s_d;
            h_q   <= h_d;
            y_q   <= y_d;
            yv_q  <= yv_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.x_q     = x_q;
    assign bus.s_q     = s_q;
    assign bus.h_q     = h_q;
    assign bus.y_out   = y_q;
    assign bus.y_valid = yv_q;
    assign bus.ovf     = ovf_q;

endmodule
